mouse_cfg_sched: RTL and testbench

MOUSE_CFG_SCHED -- requirements
Module: mouse_cfg_sched

---
 rtl/mouse_cfg_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mouse_cfg_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cfg_sched.sv
// Boot/resolution/warp strobe scheduler for the mouse core.
// Optional MOUSE_CFG_CLAMP_EN clamps warp targets to the current limits.
module mouse_cfg_sched #(
  parameter int MAX_X = 639,
  parameter int MAX_Y = 479,
  parameter int GAP   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        res_req,
  input  logic [11:0] res_max_x,
  input  logic [11:0] res_max_y,
  output logic        res_ack,
  input  logic        warp_req,
  input  logic [11:0] warp_x,
  input  logic [11:0] warp_y,
  output logic        warp_ack,
  output logic [11:0] set_value,
  output logic        set_x_max,
  output logic        set_y_max,
  output logic        set_x,
  output logic        set_y,
  output logic        busy,
  output logic [11:0] cur_max_x,
  output logic [11:0] cur_max_y
);

  localparam int CW = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(GAP - 1);
  localparam logic [11:0] LIM_X = 12'(MAX_X);
  localparam logic [11:0] LIM_Y = 12'(MAX_Y);

  typedef enum logic [3:0] {
    BOOT_XMAX,
    BOOT_YMAX,
    BOOT_X,
    BOOT_Y,
    RES_X,
    RES_Y,
    WARP_X,
    WARP_Y,
    HOLD,
    IDLE
  } state_e;

  state_e        state_q, state_d;
  state_e        nxt_q, nxt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic [11:0]   res_x_q, res_x_d;
  logic [11:0]   res_y_q, res_y_d;
  logic [11:0]   wx_q, wx_d;
  logic [11:0]   wy_q, wy_d;

  logic [11:0] set_value_q, set_value_d;
  logic        sxm_q, sxm_d;
  logic        sym_q, sym_d;
  logic        sx_q, sx_d;
  logic        sy_q, sy_d;
  logic        res_ack_q, res_ack_d;
  logic        warp_ack_q, warp_ack_d;
  logic        busy_q, busy_d;
  logic [11:0] cur_x_q, cur_x_d;
  logic [11:0] cur_y_q, cur_y_d;

  logic        grant_res;
  logic        grant_warp;
  logic [11:0] wx_in;
  logic [11:0] wy_in;

  // rr_q set means the last contested grant went to res, so warp wins next tie
  assign grant_res  = res_req & (~warp_req | ~rr_q);
  assign grant_warp = warp_req & ~grant_res;

`ifdef MOUSE_CFG_CLAMP_EN
  assign wx_in = (warp_x > cur_x_q) ? cur_x_q : warp_x;
  assign wy_in = (warp_y > cur_y_q) ? cur_y_q : warp_y;
`else
  assign wx_in = warp_x;
  assign wy_in = warp_y;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= BOOT_XMAX;
      nxt_q       <= BOOT_XMAX;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      wx_q        <= '0;
      wy_q        <= '0;
      set_value_q <= '0;
      sxm_q       <= 1'b0;
      sym_q       <= 1'b0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      res_ack_q   <= 1'b0;
      warp_ack_q  <= 1'b0;
      busy_q      <= 1'b1;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      nxt_q       <= nxt_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      set_value_q <= set_value_d;
      sxm_q       <= sxm_d;
      sym_q       <= sym_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      res_ack_q   <= res_ack_d;
      warp_ack_q  <= warp_ack_d;
      busy_q      <= busy_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    unique case (state_q)
      BOOT_XMAX: begin
        state_d = HOLD;
        nxt_d   = BOOT_YMAX;
        cnt_d   = HOLD_INIT;
      end
      BOOT_YMAX: begin
        state_d = HOLD;
        nxt_d   = BOOT_X;
        cnt_d   = HOLD_INIT;
      end
      BOOT_X: begin
        state_d = HOLD;
        nxt_d   = BOOT_Y;
        cnt_d   = HOLD_INIT;
      end
      BOOT_Y: begin
        state_d = HOLD;
        nxt_d   = IDLE;
        cnt_d   = HOLD_INIT;
      end
      RES_X: begin
        state_d = HOLD;
        nxt_d   = RES_Y;
        cnt_d   = HOLD_INIT;
      end
      RES_Y: begin
        state_d = HOLD;
        nxt_d   = IDLE;
        cnt_d   = HOLD_INIT;
      end
      WARP_X: begin
        state_d = HOLD;
        nxt_d   = WARP_Y;
        cnt_d   = HOLD_INIT;
      end
      WARP_Y: begin
        state_d = HOLD;
        nxt_d   = IDLE;
        cnt_d   = HOLD_INIT;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = nxt_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      IDLE: begin
        unique case (1'b1)
          grant_res: begin
            state_d = RES_X;
            res_x_d = res_max_x;
            res_y_d = res_max_y;
          end
          grant_warp: begin
            state_d = WARP_X;
            wx_d    = wx_in;
            wy_d    = wy_in;
          end
          default: ;
        endcase
        if (res_req && warp_req) begin
          rr_d = grant_res;
        end
      end
      default: state_d = BOOT_XMAX;
    endcase
  end

  always_comb begin
    set_value_d = '0;
    sxm_d       = 1'b0;
    sym_d       = 1'b0;
    sx_d        = 1'b0;
    sy_d        = 1'b0;
    res_ack_d   = 1'b0;
    warp_ack_d  = 1'b0;
    busy_d      = (state_q != IDLE);
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    unique case (state_q)
      BOOT_XMAX: begin
        sxm_d       = 1'b1;
        set_value_d = LIM_X;
        cur_x_d     = LIM_X;
      end
      BOOT_YMAX: begin
        sym_d       = 1'b1;
        set_value_d = LIM_Y;
        cur_y_d     = LIM_Y;
      end
      BOOT_X: begin
        sx_d        = 1'b1;
        set_value_d = LIM_X >> 1;
      end
      BOOT_Y: begin
        sy_d        = 1'b1;
        set_value_d = LIM_Y >> 1;
      end
      RES_X: begin
        sxm_d       = 1'b1;
        set_value_d = res_x_q;
        cur_x_d     = res_x_q;
      end
      RES_Y: begin
        sym_d       = 1'b1;
        set_value_d = res_y_q;
        cur_y_d     = res_y_q;
        res_ack_d   = 1'b1;
      end
      WARP_X: begin
        sx_d        = 1'b1;
        set_value_d = wx_q;
      end
      WARP_Y: begin
        sy_d        = 1'b1;
        set_value_d = wy_q;
        warp_ack_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign set_value = set_value_q;
  assign set_x_max = sxm_q;
  assign set_y_max = sym_q;
  assign set_x     = sx_q;
  assign set_y     = sy_q;
  assign res_ack   = res_ack_q;
  assign warp_ack  = warp_ack_q;
  assign busy      = busy_q;
  assign cur_max_x = cur_x_q;
  assign cur_max_y = cur_y_q;

endmodule

// File: tb/tb_mouse_cfg_sched.sv
// Scoreboard bench for mouse_cfg_sched: directed requests push expected
// strobes, a negedge monitor pops and compares.
module tb_mouse_cfg_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        res_req = 1'b0;
  logic [11:0] res_max_x = '0;
  logic [11:0] res_max_y = '0;
  logic        res_ack;
  logic        warp_req = 1'b0;
  logic [11:0] warp_x = '0;
  logic [11:0] warp_y = '0;
  logic        warp_ack;
  logic [11:0] set_value;
  logic        set_x_max, set_y_max, set_x, set_y;
  logic        busy;
  logic [11:0] cur_max_x, cur_max_y;

  mouse_cfg_sched dut (
    .clock(clock), .reset(reset),
    .res_req(res_req), .res_max_x(res_max_x), .res_max_y(res_max_y),
    .res_ack(res_ack),
    .warp_req(warp_req), .warp_x(warp_x), .warp_y(warp_y),
    .warp_ack(warp_ack),
    .set_value(set_value),
    .set_x_max(set_x_max), .set_y_max(set_y_max),
    .set_x(set_x), .set_y(set_y),
    .busy(busy), .cur_max_x(cur_max_x), .cur_max_y(cur_max_y)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;
    int val;
    int ra;
    int wa;
    int cyc;
    int dly;
    int cmx;
    int cmy;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_base = 0;
  int last_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic push(input int kind, input int val, input int ra,
                      input int wa, input int c, input int d,
                      input int cmx, input int cmy);
    item_t it;
    it.kind = kind; it.val = val; it.ra = ra; it.wa = wa;
    it.cyc = c; it.dly = d; it.cmx = cmx; it.cmy = cmy;
    exp_q.push_back(it);
  endtask

  function automatic int clampv(input int v, input int lim);
`ifdef MOUSE_CFG_CLAMP_EN
    return (v > lim) ? lim : v;
`else
    return v + 0 * lim;
`endif
  endfunction

  // monitor
  always @(negedge clock) begin
    int strb;
    int rel;
    item_t it;
    if (!reset) begin
      strb = {28'd0, set_y, set_x, set_y_max, set_x_max};
      rel  = cyc - rel_base;
      if (strb != 0 || res_ack || warp_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobes %0d value %0d expected none",
                   strb, set_value);
        end else begin
          it = exp_q.pop_front();
          chk("strobe_kind", strb, 1 << it.kind);
          chk("set_value", int'(set_value), it.val);
          chk("res_ack", int'(res_ack), it.ra);
          chk("warp_ack", int'(warp_ack), it.wa);
          chk("cur_max_x", int'(cur_max_x), it.cmx);
          chk("cur_max_y", int'(cur_max_y), it.cmy);
          if (it.cyc >= 0) chk("strobe_cycle", rel, it.cyc);
          if (it.dly >= 0) chk("strobe_spacing", rel - last_cyc, it.dly);
        end
        last_cyc = rel;
      end else begin
        chk("idle_set_value", int'(set_value), 0);
      end
    end
  end

  task automatic wait_idle(output int rel);
    int got;
    got = 0;
    rel = -1;
    for (int i = 0; i < 300 && got == 0; i++) begin
      @(negedge clock);
      if (!busy) begin
        got = 1;
        rel = cyc - rel_base;
      end
    end
    chk("idle_reached", got, 1);
  endtask

  task automatic req_res(input int x, input int y);
    int got;
    res_req = 1'b1;
    res_max_x = 12'(x);
    res_max_y = 12'(y);
    got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      @(negedge clock);
      got = int'(res_ack);
    end
    chk("res_ack_seen", got, 1);
    res_req = 1'b0;
  endtask

  task automatic req_warp(input int x, input int y, input int corrupt);
    int got;
    warp_req = 1'b1;
    warp_x = 12'(x);
    warp_y = 12'(y);
    got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      @(negedge clock);
      if (corrupt != 0 && i == 0) begin
        warp_x = 12'd5;
        warp_y = 12'd7;
      end
      got = int'(warp_ack);
    end
    chk("warp_ack_seen", got, 1);
    warp_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_strobes", int'({set_y, set_x, set_y_max, set_x_max}), 0);
    chk("rst_set_value", int'(set_value), 0);
    chk("rst_acks", int'({res_ack, warp_ack}), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cur_max_x", int'(cur_max_x), 0);
    chk("rst_cur_max_y", int'(cur_max_y), 0);
  endtask

  task automatic push_boot();
    push(0, 639, 0, 0, 1, -1, 639, 0);
    push(1, 479, 0, 0, 4, 3, 639, 479);
    push(2, 319, 0, 0, 7, 3, 639, 479);
    push(3, 239, 0, 0, 10, 3, 639, 479);
  endtask

  initial begin
    int rel;
    int got;
    repeat (3) @(negedge clock);
    check_reset_outputs();

    // boot sequence
    push_boot();
    reset = 1'b0;
    rel_base = cyc;
    wait_idle(rel);
    chk("boot_busy_low_cycle", rel, 13);
    chk("boot_cur_max_x", int'(cur_max_x), 639);
    chk("boot_cur_max_y", int'(cur_max_y), 479);

    // single resolution change
    push(0, 799, 0, 0, -1, -1, 799, 479);
    push(1, 599, 1, 0, -1, 3, 799, 599);
    req_res(799, 599);
    wait_idle(rel);
    chk("res_cur_max_x", int'(cur_max_x), 799);
    chk("res_cur_max_y", int'(cur_max_y), 599);

    // first tie: res wins
    push(0, 700, 0, 0, -1, -1, 700, 599);
    push(1, 500, 1, 0, -1, 3, 700, 500);
    push(2, 100, 0, 0, -1, 4, 700, 500);
    push(3, 200, 0, 1, -1, 3, 700, 500);
    fork
      req_res(700, 500);
      req_warp(100, 200, 0);
    join
    wait_idle(rel);

    // second tie: warp wins, clamped against 700/500 when enabled
    push(2, clampv(1000, 700), 0, 0, -1, -1, 700, 500);
    push(3, 50, 0, 1, -1, 3, 700, 500);
    push(0, 639, 0, 0, -1, 4, 639, 500);
    push(1, 479, 1, 0, -1, 3, 639, 479);
    fork
      req_res(639, 479);
      req_warp(1000, 50, 0);
    join
    wait_idle(rel);

    // warp beyond limits 639/479
    push(2, clampv(1000, 639), 0, 0, -1, -1, 639, 479);
    push(3, 50, 0, 1, -1, 3, 639, 479);
    req_warp(1000, 50, 0);
    wait_idle(rel);

    // inputs change after grant; captured values must be used
    push(2, 300, 0, 0, -1, -1, 639, 479);
    push(3, 200, 0, 1, -1, 3, 639, 479);
    req_warp(300, 200, 1);
    wait_idle(rel);

    // zero limits are forwarded unchanged
    push(0, 0, 0, 0, -1, -1, 0, 479);
    push(1, 0, 1, 0, -1, 3, 0, 0);
    req_res(0, 0);
    wait_idle(rel);
    chk("zero_cur_max_x", int'(cur_max_x), 0);
    chk("zero_cur_max_y", int'(cur_max_y), 0);

    // reset between RES_X and RES_Y
    push(0, 600, 0, 0, -1, -1, 600, 0);
    res_req = 1'b1;
    res_max_x = 12'd600;
    res_max_y = 12'd400;
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clock);
      got = int'(set_x_max);
    end
    chk("abort_res_x_seen", got, 1);
    @(negedge clock);
    reset = 1'b1;
    res_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_no_set_y_max", int'(set_y_max), 0);
      chk("abort_no_res_ack", int'(res_ack), 0);
    end
    check_reset_outputs();
    push_boot();
    reset = 1'b0;
    rel_base = cyc;
    wait_idle(rel);
    chk("reboot_busy_low_cycle", rel, 13);
    chk("reboot_cur_max_x", int'(cur_max_x), 639);
    chk("reboot_cur_max_y", int'(cur_max_y), 479);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
